// File: rtl/up_to_limit_if.sv
// Control/status bundle for the up_to_limit timer: the master drives the commands and the limit,
// the slave (the timer) returns the count, busy and the done pulse.
interface up_to_limit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             tick;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q_bus;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, clear, tick, limit,
    input  q_bus, busy, done
  );

  modport slave (
    input  start, stop, clear, tick, limit,
    output q_bus, busy, done
  );
endinterface

// File: rtl/up_to_limit.sv
// Up-counting timer: counts ticks from 0 up to a latched (clamped) limit, then pulses done.
// Optional UP_TO_LIMIT_AUTO_RELOAD_EN: wrap to 0 on reaching the limit and keep counting.
module up_to_limit #(
  parameter int WIDTH     = 4,
  parameter int MAX_LIMIT = 15
) (
  input  logic             clock,
  input  logic             reset,
  up_to_limit_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_LIMIT);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_limit;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_limit_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_lim_clamped;
  logic             w_counting;
  logic             w_stop_hit;
  logic             w_last_tick;

  assign w_lim_clamped = (bus.limit > MAX_L) ? MAX_L : bus.limit;
  assign w_counting    = (r_state == S_COUNTING);
  // stop only matters while counting, so outside COUNTING a start beneath it still wins
  assign w_stop_hit    = bus.stop && w_counting;
  assign w_last_tick   = bus.tick && w_counting && (r_q == r_limit - WIDTH'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_limit <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_limit <= w_limit_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else if (w_stop_hit) begin
      w_state_nxt = S_IDLE;
    end else if (bus.start) begin
      w_state_nxt = (w_lim_clamped == '0) ? S_DONE : S_COUNTING;
    end else if (w_last_tick) begin
`ifdef UP_TO_LIMIT_AUTO_RELOAD_EN
      w_state_nxt = S_COUNTING;
`else
      w_state_nxt = S_DONE;
`endif
    end
  end

  always_comb begin
    w_q_nxt     = r_q;
    w_limit_nxt = r_limit;
    w_done_nxt  = 1'b0;
    if (bus.clear) begin
      w_q_nxt = '0;
    end else if (w_stop_hit) begin
      w_q_nxt = r_q;
    end else if (bus.start) begin
      w_q_nxt     = '0;
      w_limit_nxt = w_lim_clamped;
      w_done_nxt  = (w_lim_clamped == '0);
    end else if (w_last_tick) begin
`ifdef UP_TO_LIMIT_AUTO_RELOAD_EN
      w_q_nxt    = '0;
`else
      w_q_nxt    = r_limit;
`endif
      w_done_nxt = 1'b1;
    end else if (bus.tick && w_counting) begin
      w_q_nxt = r_q + WIDTH'(1);
    end
    w_busy_nxt = (w_state_nxt == S_COUNTING);
  end

  assign bus.q_bus = r_q;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_up_to_limit.sv
// Directed bench for up_to_limit: a WIDTH=4 instance for the main sequences and a WIDTH=5
// instance for limit clamping; expectations adapt to UP_TO_LIMIT_AUTO_RELOAD_EN.
module tb_up_to_limit;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  up_to_limit_if #(.WIDTH(4)) if0 ();
  up_to_limit_if #(.WIDTH(5)) if1 ();

  up_to_limit #(.WIDTH(4), .MAX_LIMIT(15)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0.slave)
  );

  up_to_limit #(.WIDTH(5), .MAX_LIMIT(15)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

`ifdef UP_TO_LIMIT_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk0(input string tag, input int q, input bit b, input bit d);
    check({tag, ".q"},    32'(if0.q_bus), 32'(q));
    check({tag, ".busy"}, 32'(if0.busy),  32'(b));
    check({tag, ".done"}, 32'(if0.done),  32'(d));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    {if0.start, if0.stop, if0.clear, if0.tick} = 4'b0;
    if0.limit = '0;
    {if1.start, if1.stop, if1.clear, if1.tick} = 4'b0;
    if1.limit = '0;
    repeat (2) step();
    chk0("reset", 0, 0, 0);
    reset = 1'b0;

    // basic run to limit 3
    if0.start = 1'b1; if0.limit = 4'd3;
    step();
    if0.start = 1'b0;
    chk0("basic_start", 0, 1, 0);
    if0.tick = 1'b1;
    step(); chk0("basic_t1", 1, 1, 0);
    step(); chk0("basic_t2", 2, 1, 0);
    step(); chk0("basic_t3", AUTO ? 0 : 3, AUTO, 1);
    step(); chk0("basic_t4", AUTO ? 1 : 3, AUTO, 0);
    if0.tick = 1'b0;

    // pause and resume
    if0.start = 1'b1; if0.limit = 4'd6;
    step();
    if0.start = 1'b0; if0.tick = 1'b1;
    step(); step();
    chk0("pause_cnt", 2, 1, 0);
    if0.tick = 1'b0; if0.stop = 1'b1;
    step();
    if0.stop = 1'b0;
    chk0("pause_stop", 2, 0, 0);
    if0.tick = 1'b1; if0.limit = 4'd9;
    step(); step();
    chk0("pause_ign", 2, 0, 0);
    if0.tick = 1'b0; if0.start = 1'b1; if0.limit = 4'd4;
    step();
    if0.start = 1'b0;
    chk0("resume", 0, 1, 0);

    // all controls at once while counting at 4
    if0.start = 1'b1; if0.limit = 4'd6;
    step();
    if0.start = 1'b0; if0.tick = 1'b1;
    repeat (4) step();
    chk0("prio_pre", 4, 1, 0);
    {if0.clear, if0.stop, if0.start, if0.tick} = 4'b1111; if0.limit = 4'd7;
    step();
    {if0.clear, if0.stop, if0.start, if0.tick} = 4'b0001;
    chk0("prio_all", 0, 0, 0);
    step();
    chk0("prio_idle_tick", 0, 0, 0);

    // start with tick on the same edge: tick not counted
    if0.start = 1'b1; if0.limit = 4'd2;
    step();
    if0.start = 1'b0;
    chk0("st_tick", 0, 1, 0);
    step(); chk0("st_t1", 1, 1, 0);
    step(); chk0("st_t2", AUTO ? 0 : 2, AUTO, 1);
    if0.tick = 1'b0;

    // start limit 0 right after done
    if0.start = 1'b1; if0.limit = 4'd0;
    step();
    if0.start = 1'b0;
    chk0("lim0", 0, 0, 1);
    if0.tick = 1'b1;
    step(); chk0("lim0_after", 0, 0, 0);
    step(); chk0("lim0_tick", 0, 0, 0);
    if0.tick = 1'b0;

    // clear in DONE keeps state idle, count 0
    if0.clear = 1'b1;
    step();
    if0.clear = 1'b0;
    chk0("clear_done", 0, 0, 0);

    // reset mid-count, asynchronous
    if0.start = 1'b1; if0.limit = 4'd5;
    step();
    if0.start = 1'b0; if0.tick = 1'b1;
    step(); step();
    chk0("rst_pre", 2, 1, 0);
    if0.tick = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk0("rst_async", 0, 0, 0);
    step();
    chk0("rst_hold", 0, 0, 0);
    reset = 1'b0;
    if0.tick = 1'b1;
    step();
    chk0("rst_idle", 0, 0, 0);
    if0.tick = 1'b0;

    // clamp: limit 20 on WIDTH=5 completes after 15 ticks
    if1.start = 1'b1; if1.limit = 5'd20;
    step();
    if1.start = 1'b0;
    check("clamp_busy", 32'(if1.busy), 32'(1));
    if1.tick = 1'b1;
    repeat (14) step();
    check("clamp_q14", 32'(if1.q_bus), 32'(14));
    check("clamp_d14", 32'(if1.done), 32'(0));
    step();
    check("clamp_q15", 32'(if1.q_bus), AUTO ? 32'(0) : 32'(15));
    check("clamp_d15", 32'(if1.done), 32'(1));
    check("clamp_b15", 32'(if1.busy), 32'(AUTO));
    if1.tick = 1'b0;

`ifdef UP_TO_LIMIT_AUTO_RELOAD_EN
    // periodic done every 2 ticks
    if0.start = 1'b1; if0.limit = 4'd2;
    step();
    if0.start = 1'b0; if0.tick = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk0($sformatf("auto_t%0d", i), (i % 2 == 1) ? 1 : 0, 1, (i % 2 == 0));
    end
    if0.tick = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
